// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the memory/write-back stage.
// Opcode encodings match the execute stage's wb_op field.
package wb_stage_pkg;

    localparam int FULLW = 32;
    localparam int WIDTH = 8;
    localparam int WORD  = FULLW / WIDTH;

    typedef enum logic [2:0] {
        WB_NOP  = 3'd0,
        WB_ALU  = 3'd1,
        WB_LDR  = 3'd2,
        WB_LDRB = 3'd3,
        WB_STR  = 3'd4,
        WB_STRB = 3'd5,
        WB_B    = 3'd6,
        WB_BL   = 3'd7
    } wb_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_REQ  = 2'd1,
        LD_DATA = 2'd2,
        LINK    = 2'd3
    } wb_state_t;

    // Word-align a byte address by clearing the lane bits.
    function automatic logic [FULLW-1:0] word_addr(input logic [FULLW-1:0] a);
        return {a[FULLW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Execute -> write-back handshake bundle.
// master = execute side, slave = write-back stage.
interface wb_stage_if #(
    parameter int ADDR_WIDTH = 4
);
    import wb_stage_pkg::*;

    logic                  ex_valid;
    logic                  ex_ready;
    wb_op_t                ex_op;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic [FULLW-1:0]      ex_result;
    logic [FULLW-1:0]      ex_sdata;
    logic [FULLW-1:0]      ex_link;

    modport master (
        output ex_valid, ex_op, ex_rd, ex_result, ex_sdata, ex_link,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_op, ex_rd, ex_result, ex_sdata, ex_link,
        output ex_ready
    );

endinterface

// File: rtl/wb_stage_ld_align.sv
// Byte-lane handling for loads and stores.
// Lane 0 is the MSB byte (big-endian lane order).
module wb_stage_ld_align
    import wb_stage_pkg::*;
(
    input  logic [FULLW-1:0] rdata,
    input  logic [1:0]       ld_lane,
    input  logic             ld_byte,
    output logic [FULLW-1:0] ld_data,
    input  logic [FULLW-1:0] sdata,
    input  logic [1:0]       st_lane,
    input  logic             st_byte,
    output logic [WORD-1:0]  st_be,
    output logic [FULLW-1:0] st_wdata
);

    logic [WIDTH-1:0] lane_byte;

    // Select the addressed byte and zero-extend for byte loads.
    always_comb begin
        lane_byte = rdata[31:24];
        unique case (ld_lane)
            2'd0: lane_byte = rdata[31:24];
            2'd1: lane_byte = rdata[23:16];
            2'd2: lane_byte = rdata[15:8];
            2'd3: lane_byte = rdata[7:0];
            default: lane_byte = rdata[31:24];
        endcase
        ld_data = ld_byte ? {24'b0, lane_byte} : rdata;
    end

    // Byte stores drive one lane and replicate the byte everywhere.
    always_comb begin
        st_be    = st_byte ? (4'b1000 >> st_lane) : 4'b1111;
        st_wdata = st_byte ? {WORD{sdata[7:0]}} : sdata;
    end

endmodule

// File: rtl/wb_stage.sv
// Memory/write-back stage: data-memory access, register write port,
// and branch strobes. Loads and BL stall execute for extra cycles.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_stage_if.slave             ex,
    output logic [FULLW-1:0]      dmem_addr,
    output logic                  dmem_re,
    output logic                  dmem_we,
    output logic [WORD-1:0]       dmem_be,
    output logic [FULLW-1:0]      dmem_wdata,
    input  logic [FULLW-1:0]      dmem_rdata,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [FULLW-1:0]      wd,
    output logic                  ib,
    output logic [FULLW-1:0]      bv,
    output logic                  bl
);

    localparam logic [ADDR_WIDTH-1:0] LR = ADDR_WIDTH'(14);

    wb_state_t             state, state_d;
    logic                  ready_q, ready_d;
    logic [ADDR_WIDTH-1:0] ld_rd, ld_rd_d;
    logic [1:0]            ld_lane, ld_lane_d;
    logic                  ld_byte, ld_byte_d;
    logic [FULLW-1:0]      link_q, link_d;

    logic [FULLW-1:0]      addr_d, wdata_d, wd_d, bv_d;
    logic [WORD-1:0]       be_d;
    logic [ADDR_WIDTH-1:0] wa_d;
    logic                  re_d, dwe_d, we_d, ib_d, bl_d;

    logic [FULLW-1:0]      ld_data, st_wdata;
    logic [WORD-1:0]       st_be;
    logic                  accept;

    assign ex.ex_ready = ready_q;
    assign accept      = ex.ex_valid & ready_q;

    wb_stage_ld_align u_align (
        .rdata    (dmem_rdata),
        .ld_lane  (ld_lane),
        .ld_byte  (ld_byte),
        .ld_data  (ld_data),
        .sdata    (ex.ex_sdata),
        .st_lane  (ex.ex_result[1:0]),
        .st_byte  (ex.ex_op == WB_STRB),
        .st_be    (st_be),
        .st_wdata (st_wdata)
    );

    // Next state and next registered outputs; data holds, strobes pulse.
    always_comb begin
        state_d   = state;
        ld_rd_d   = ld_rd;
        ld_lane_d = ld_lane;
        ld_byte_d = ld_byte;
        link_d    = link_q;
        addr_d    = dmem_addr;
        be_d      = dmem_be;
        wdata_d   = dmem_wdata;
        wa_d      = wa;
        wd_d      = wd;
        bv_d      = bv;
        re_d      = 1'b0;
        dwe_d     = 1'b0;
        we_d      = 1'b0;
        ib_d      = 1'b0;
        bl_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (ex.ex_op)
                        WB_ALU: begin
                            we_d = 1'b1;
                            wa_d = ex.ex_rd;
                            wd_d = ex.ex_result;
                        end
                        WB_LDR, WB_LDRB: begin
                            ld_rd_d   = ex.ex_rd;
                            ld_lane_d = ex.ex_result[1:0];
                            ld_byte_d = (ex.ex_op == WB_LDRB);
                            addr_d    = word_addr(ex.ex_result);
                            re_d      = 1'b1;
                            state_d   = LD_REQ;
                        end
                        WB_STR, WB_STRB: begin
                            addr_d  = word_addr(ex.ex_result);
                            be_d    = st_be;
                            wdata_d = st_wdata;
                            dwe_d   = 1'b1;
                        end
                        WB_B: begin
                            ib_d = 1'b1;
                            bv_d = ex.ex_result;
                        end
                        WB_BL: begin
                            ib_d    = 1'b1;
                            bl_d    = 1'b1;
                            bv_d    = ex.ex_result;
                            link_d  = ex.ex_link;
                            state_d = LINK;
                        end
                        default: ;
                    endcase
                end
            end
            LD_REQ: state_d = LD_DATA;
            LD_DATA: begin
                we_d    = 1'b1;
                wa_d    = ld_rd;
                wd_d    = ld_data;
                state_d = IDLE;
            end
            LINK: begin
                we_d    = 1'b1;
                wa_d    = LR;
                wd_d    = link_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and internal latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            ld_rd   <= '0;
            ld_lane <= '0;
            ld_byte <= 1'b0;
            link_q  <= '0;
        end else begin
            state   <= state_d;
            ready_q <= ready_d;
            ld_rd   <= ld_rd_d;
            ld_lane <= ld_lane_d;
            ld_byte <= ld_byte_d;
            link_q  <= link_d;
        end
    end

    // Registered memory, register-file and branch outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_addr  <= '0;
            dmem_re    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            ib         <= 1'b0;
            bv         <= '0;
            bl         <= 1'b0;
        end else begin
            dmem_addr  <= addr_d;
            dmem_re    <= re_d;
            dmem_we    <= dwe_d;
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
            we         <= we_d;
            wa         <= wa_d;
            wd         <= wd_d;
            ib         <= ib_d;
            bv         <= bv_d;
            bl         <= bl_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU, loads, stores, branches, reset.
// Inputs change #1 after a rising edge; outputs sampled there too.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wd, bv;
    logic        dmem_re, dmem_we, we, ib, bl;
    logic [3:0]  dmem_be, wa;

    int n_chk;
    int n_err;

    wb_stage_if #(.ADDR_WIDTH(4)) exi ();

    wb_stage #(.ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex         (exi.slave),
        .dmem_addr  (dmem_addr),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .ib         (ib),
        .bv         (bv),
        .bl         (bl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input wb_op_t op,
                         input logic [3:0] rd, input logic [31:0] res,
                         input logic [31:0] sd, input logic [31:0] lk);
        exi.ex_valid  = v;
        exi.ex_op     = op;
        exi.ex_rd     = rd;
        exi.ex_result = res;
        exi.ex_sdata  = sd;
        exi.ex_link   = lk;
    endtask

    task automatic idle();
        drive(1'b0, WB_NOP, 4'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        dmem_rdata = 32'h0;
        idle();
        tick();
        tick();
        check("rst_ready", {31'b0, exi.ex_ready}, 32'd0);
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_ib", {31'b0, ib}, 32'd0);
        reset = 1'b0;
        tick();
        check("ready_after_rst", {31'b0, exi.ex_ready}, 32'd1);

        // ALU back-to-back
        drive(1'b1, WB_ALU, 4'd3, 32'hDEADBEEF, 32'd0, 32'd0);
        tick();
        check("alu1_we", {31'b0, we}, 32'd1);
        check("alu1_wa", {28'b0, wa}, 32'd3);
        check("alu1_wd", wd, 32'hDEADBEEF);
        check("alu1_ready", {31'b0, exi.ex_ready}, 32'd1);
        drive(1'b1, WB_ALU, 4'd4, 32'd1, 32'd0, 32'd0);
        tick();
        check("alu2_we", {31'b0, we}, 32'd1);
        check("alu2_wa", {28'b0, wa}, 32'd4);
        check("alu2_wd", wd, 32'd1);
        idle();
        tick();
        check("alu_we_drop", {31'b0, we}, 32'd0);
        check("alu_wd_hold", wd, 32'd1);

        // NOP: no strobes
        drive(1'b1, WB_NOP, 4'd7, 32'h55, 32'd0, 32'd0);
        tick();
        check("nop_strobes", {27'b0, we, ib, bl, dmem_re, dmem_we}, 32'd0);
        idle();

        // LDRB with an ALU held during back-pressure
        dmem_rdata = 32'h11223344;
        drive(1'b1, WB_LDRB, 4'd5, 32'h102, 32'd0, 32'd0);
        tick();
        check("ldrb_re", {31'b0, dmem_re}, 32'd1);
        check("ldrb_addr", dmem_addr, 32'h100);
        check("ldrb_ready_n1", {31'b0, exi.ex_ready}, 32'd0);
        check("ldrb_we_n1", {31'b0, we}, 32'd0);
        drive(1'b1, WB_ALU, 4'd6, 32'd7, 32'd0, 32'd0);
        tick();
        check("ldrb_re_n2", {31'b0, dmem_re}, 32'd0);
        check("ldrb_ready_n2", {31'b0, exi.ex_ready}, 32'd0);
        check("ldrb_we_n2", {31'b0, we}, 32'd0);
        tick();
        check("ldrb_we", {31'b0, we}, 32'd1);
        check("ldrb_wa", {28'b0, wa}, 32'd5);
        check("ldrb_wd", wd, 32'h00000033);
        check("ldrb_ready_n3", {31'b0, exi.ex_ready}, 32'd1);
        tick();
        check("held_alu_we", {31'b0, we}, 32'd1);
        check("held_alu_wa", {28'b0, wa}, 32'd6);
        check("held_alu_wd", wd, 32'd7);
        idle();
        tick();

        // STRB and STR
        drive(1'b1, WB_STRB, 4'd0, 32'h43, 32'h000000AB, 32'd0);
        tick();
        check("strb_we", {31'b0, dmem_we}, 32'd1);
        check("strb_be", {28'b0, dmem_be}, 32'h1);
        check("strb_wdata", dmem_wdata, 32'hABABABAB);
        check("strb_addr", dmem_addr, 32'h40);
        check("strb_rf_we", {31'b0, we}, 32'd0);
        drive(1'b1, WB_STR, 4'd0, 32'h1007, 32'hCAFEF00D, 32'd0);
        tick();
        check("str_be", {28'b0, dmem_be}, 32'hF);
        check("str_wdata", dmem_wdata, 32'hCAFEF00D);
        check("str_addr", dmem_addr, 32'h1004);
        idle();
        tick();
        check("str_we_drop", {31'b0, dmem_we}, 32'd0);
        check("str_be_hold", {28'b0, dmem_be}, 32'hF);

        // BL with an ALU held during N+1
        drive(1'b1, WB_BL, 4'd0, 32'h80, 32'd0, 32'h24);
        tick();
        check("bl_ib", {31'b0, ib}, 32'd1);
        check("bl_bl", {31'b0, bl}, 32'd1);
        check("bl_bv", bv, 32'h80);
        check("bl_ready_n1", {31'b0, exi.ex_ready}, 32'd0);
        check("bl_we_n1", {31'b0, we}, 32'd0);
        drive(1'b1, WB_ALU, 4'd9, 32'h55, 32'd0, 32'd0);
        tick();
        check("link_we", {31'b0, we}, 32'd1);
        check("link_wa", {28'b0, wa}, 32'd14);
        check("link_wd", wd, 32'h24);
        check("link_ib_drop", {31'b0, ib}, 32'd0);
        check("link_ready", {31'b0, exi.ex_ready}, 32'd1);
        tick();
        check("bl_held_wa", {28'b0, wa}, 32'd9);
        check("bl_held_wd", wd, 32'h55);

        // Plain branch
        drive(1'b1, WB_B, 4'd0, 32'h200, 32'd0, 32'h99);
        tick();
        check("b_ib", {31'b0, ib}, 32'd1);
        check("b_bl", {31'b0, bl}, 32'd0);
        check("b_bv", bv, 32'h200);
        check("b_ready", {31'b0, exi.ex_ready}, 32'd1);
        idle();
        tick();

        // LDR to r15, unaligned address
        dmem_rdata = 32'hA5A51234;
        drive(1'b1, WB_LDR, 4'd15, 32'h23, 32'd0, 32'd0);
        tick();
        check("ldr_addr", dmem_addr, 32'h20);
        idle();
        tick();
        tick();
        check("ldr_we", {31'b0, we}, 32'd1);
        check("ldr_wa", {28'b0, wa}, 32'd15);
        check("ldr_wd", wd, 32'hA5A51234);
        tick();

        // Reset during LD_DATA
        drive(1'b1, WB_LDR, 4'd2, 32'h8, 32'd0, 32'd0);
        tick();
        idle();
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_ready", {31'b0, exi.ex_ready}, 32'd0);
        check("rst_mid_addr", dmem_addr, 32'd0);
        check("rst_mid_strobes", {30'b0, we, dmem_re}, 32'd0);
        tick();
        check("rst_mid_we", {31'b0, we}, 32'd0);
        reset = 1'b0;
        tick();
        check("rst_rel_ready", {31'b0, exi.ex_ready}, 32'd1);
        check("rst_rel_we", {31'b0, we}, 32'd0);
        tick();
        check("rst_rel_we2", {31'b0, we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
